// File: rtl/lpif_x4_half_slave_rx_align.sv
// Slave-end receive alignment for the x4 half-rate LPIF link: waits the configured
// delay after link-up, hunts for the all-channel strobe, then locks and checks markers.
module lpif_x4_half_slave_rx_align #(
  parameter int unsigned STB_BIT    = 1,
  parameter int unsigned MRK_BIT0   = 39,
  parameter int unsigned MRK_BIT1   = 79,
  parameter logic [1:0]  MRK_EXPECT = 2'b10,
  parameter int unsigned STB_CONSEC = 4,
  parameter int unsigned MAX_ERR    = 8
) (
  input  logic         clk_wr,
  input  logic         rst_wr,
  input  logic         rx_online,
  input  logic         m_gen2_mode,
  input  logic [15:0]  delay_x_value,
  input  logic [79:0]  rx_phy0,
  input  logic [79:0]  rx_phy1,
  input  logic [79:0]  rx_phy2,
  input  logic [79:0]  rx_phy3,
  output logic [319:0] rx_data,
  output logic         rx_data_vld,
  output logic         rx_online_delay,
  output logic         rx_aligned,
  output logic [7:0]   mrk_err_cnt,
  output logic [31:0]  rx_align_debug_status
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT_X = 2'd1;
  localparam logic [1:0] ST_HUNT   = 2'd2;
  localparam logic [1:0] ST_LOCKED = 2'd3;

  localparam logic [3:0] STB_LIMIT = 4'(STB_CONSEC);
  localparam logic [3:0] ERR_LIMIT = 4'(MAX_ERR);

  logic [1:0]  state_r, state_nxt_s;
  logic [15:0] wait_cnt_r, wait_cnt_nxt_s;
  logic [3:0]  stb_run_r, stb_run_nxt_s;
  logic [3:0]  err_run_r, err_run_nxt_s;
  logic        stb_all_s, mrk_bad_s;
  logic        vld_nxt_s, aligned_nxt_s, online_delay_nxt_s;
  logic [7:0]  err_cnt_nxt_s;

  // Gen1 links only carry a meaningful low-half marker, so bit 1 is ignored there.
  function automatic logic mrk_mismatch(input logic [79:0] word, input logic gen2);
    logic [1:0] mrk;
    mrk = {word[MRK_BIT1], word[MRK_BIT0]};
    if (gen2) begin
      mrk_mismatch = (mrk != MRK_EXPECT);
    end else begin
      mrk_mismatch = (mrk[0] != MRK_EXPECT[0]);
    end
  endfunction

  assign stb_all_s = rx_phy0[STB_BIT] & rx_phy1[STB_BIT] & rx_phy2[STB_BIT] & rx_phy3[STB_BIT];
  assign mrk_bad_s = mrk_mismatch(rx_phy0, m_gen2_mode) | mrk_mismatch(rx_phy1, m_gen2_mode) |
                     mrk_mismatch(rx_phy2, m_gen2_mode) | mrk_mismatch(rx_phy3, m_gen2_mode);

  // State and run-length counter registers.
  always_ff @(posedge clk_wr) begin
    if (rst_wr) begin
      state_r    <= ST_IDLE;
      wait_cnt_r <= 16'd0;
      stb_run_r  <= 4'd0;
      err_run_r  <= 4'd0;
    end else begin
      state_r    <= state_nxt_s;
      wait_cnt_r <= wait_cnt_nxt_s;
      stb_run_r  <= stb_run_nxt_s;
      err_run_r  <= err_run_nxt_s;
    end
  end

  // Next-state and counter logic; a dropped rx_online overrides every other transition.
  always_comb begin
    state_nxt_s    = state_r;
    wait_cnt_nxt_s = wait_cnt_r;
    stb_run_nxt_s  = stb_run_r;
    err_run_nxt_s  = err_run_r;
    if (!rx_online) begin
      state_nxt_s    = ST_IDLE;
      wait_cnt_nxt_s = 16'd0;
      stb_run_nxt_s  = 4'd0;
      err_run_nxt_s  = 4'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_nxt_s    = ST_WAIT_X;
          wait_cnt_nxt_s = delay_x_value;
        end
        ST_WAIT_X: begin
          if (wait_cnt_r == 16'd0) begin
            state_nxt_s = ST_HUNT;
          end else begin
            wait_cnt_nxt_s = wait_cnt_r - 16'd1;
          end
        end
        ST_HUNT: begin
          if (!stb_all_s) begin
            stb_run_nxt_s = 4'd0;
          end else if (stb_run_r + 4'd1 == STB_LIMIT) begin
            state_nxt_s   = ST_LOCKED;
            stb_run_nxt_s = 4'd0;
            err_run_nxt_s = 4'd0;
          end else begin
            stb_run_nxt_s = stb_run_r + 4'd1;
          end
        end
        ST_LOCKED: begin
          if (!mrk_bad_s) begin
            err_run_nxt_s = 4'd0;
          end else if (err_run_r + 4'd1 == ERR_LIMIT) begin
            state_nxt_s   = ST_HUNT;
            err_run_nxt_s = 4'd0;
            stb_run_nxt_s = 4'd0;
          end else begin
            err_run_nxt_s = err_run_r + 4'd1;
          end
        end
        default: begin
          state_nxt_s    = ST_IDLE;
          wait_cnt_nxt_s = 16'd0;
          stb_run_nxt_s  = 4'd0;
          err_run_nxt_s  = 4'd0;
        end
      endcase
    end
  end

  // Output decode: status flags follow the next state so they line up with it.
  always_comb begin
    vld_nxt_s          = (state_r == ST_LOCKED) && !mrk_bad_s;
    aligned_nxt_s      = (state_nxt_s == ST_LOCKED);
    online_delay_nxt_s = (state_nxt_s == ST_HUNT) || (state_nxt_s == ST_LOCKED);
    if ((state_r == ST_LOCKED) && mrk_bad_s && (mrk_err_cnt != 8'hFF)) begin
      err_cnt_nxt_s = mrk_err_cnt + 8'd1;
    end else begin
      err_cnt_nxt_s = mrk_err_cnt;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk_wr) begin
    if (rst_wr) begin
      rx_data         <= 320'd0;
      rx_data_vld     <= 1'b0;
      rx_online_delay <= 1'b0;
      rx_aligned      <= 1'b0;
      mrk_err_cnt     <= 8'd0;
    end else begin
      rx_data         <= {rx_phy3, rx_phy2, rx_phy1, rx_phy0};
      rx_data_vld     <= vld_nxt_s;
      rx_online_delay <= online_delay_nxt_s;
      rx_aligned      <= aligned_nxt_s;
      mrk_err_cnt     <= err_cnt_nxt_s;
    end
  end

  assign rx_align_debug_status = {20'h0, state_r, stb_run_r, err_run_r, rx_online_delay, rx_aligned};

endmodule

// File: tb/tb_lpif_x4_half_slave_rx_align.sv
// Self-checking bench for lpif_x4_half_slave_rx_align: directed scenarios plus random
// traffic, all compared against a cycle-level behavioural model of the link-up rules.
module tb_lpif_x4_half_slave_rx_align;

  localparam int unsigned STB_BIT    = 1;
  localparam int unsigned MRK_BIT0   = 39;
  localparam int unsigned MRK_BIT1   = 79;
  localparam logic [1:0]  MRK_EXPECT = 2'b10;
  localparam int unsigned STB_CONSEC = 4;
  localparam int unsigned MAX_ERR    = 8;
  localparam logic [7:0]  GOOD       = 8'b10_10_10_10;

  logic         clk = 1'b0;
  logic         rst_wr, rx_online, m_gen2_mode;
  logic [15:0]  delay_x_value;
  logic [79:0]  rx_phy0, rx_phy1, rx_phy2, rx_phy3;
  logic [319:0] rx_data;
  logic         rx_data_vld, rx_online_delay, rx_aligned;
  logic [7:0]   mrk_err_cnt;
  logic [31:0]  dbg;

  always #5 clk = ~clk;

  lpif_x4_half_slave_rx_align #(
    .STB_BIT(STB_BIT), .MRK_BIT0(MRK_BIT0), .MRK_BIT1(MRK_BIT1),
    .MRK_EXPECT(MRK_EXPECT), .STB_CONSEC(STB_CONSEC), .MAX_ERR(MAX_ERR)
  ) dut (
    .clk_wr(clk), .rst_wr(rst_wr), .rx_online(rx_online), .m_gen2_mode(m_gen2_mode),
    .delay_x_value(delay_x_value), .rx_phy0(rx_phy0), .rx_phy1(rx_phy1),
    .rx_phy2(rx_phy2), .rx_phy3(rx_phy3), .rx_data(rx_data), .rx_data_vld(rx_data_vld),
    .rx_online_delay(rx_online_delay), .rx_aligned(rx_aligned),
    .mrk_err_cnt(mrk_err_cnt), .rx_align_debug_status(dbg)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: phase 0 idle, 1 waiting, 2 hunting, 3 locked.
  int           m_phase = 0, m_wait = 0, m_stb = 0, m_err = 0, m_cnt = 0;
  logic [319:0] e_data = '0;
  logic         e_vld = 1'b0;

  logic [332:0] got_v, exp_v;
  assign got_v = {rx_data, rx_data_vld, rx_aligned, rx_online_delay, mrk_err_cnt, dbg[11:10]};
  assign exp_v = {e_data, e_vld, (m_phase == 3), (m_phase >= 2), 8'(m_cnt), 2'(m_phase)};

  function automatic logic [79:0] mk_word(input logic stb, input logic [1:0] mrk);
    logic [79:0] w;
    w = {16'($urandom), $urandom, $urandom};
    w[STB_BIT]  = stb;
    w[MRK_BIT0] = mrk[0];
    w[MRK_BIT1] = mrk[1];
    return w;
  endfunction

  task automatic set_words(input logic [3:0] stb, input logic [7:0] mrk);
    rx_phy0 = mk_word(stb[0], mrk[1:0]);
    rx_phy1 = mk_word(stb[1], mrk[3:2]);
    rx_phy2 = mk_word(stb[2], mrk[5:4]);
    rx_phy3 = mk_word(stb[3], mrk[7:6]);
  endtask

  // Applies the link-up rules to the inputs present at the coming clock edge.
  task automatic model_clock();
    logic [79:0] w [4];
    logic [1:0]  mk;
    bit          all_stb, bad;
    w[0] = rx_phy0; w[1] = rx_phy1; w[2] = rx_phy2; w[3] = rx_phy3;
    if (rst_wr) begin
      m_phase = 0; m_wait = 0; m_stb = 0; m_err = 0; m_cnt = 0;
      e_data = '0; e_vld = 1'b0;
      return;
    end
    all_stb = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mk = {w[i][MRK_BIT1], w[i][MRK_BIT0]};
      if (!w[i][STB_BIT]) all_stb = 1'b0;
      if (m_gen2_mode ? (mk != MRK_EXPECT) : (mk[0] != MRK_EXPECT[0])) bad = 1'b1;
    end
    e_data = {w[3], w[2], w[1], w[0]};
    e_vld  = (m_phase == 3) && !bad;
    if (m_phase == 3 && bad && m_cnt < 255) m_cnt++;
    if (!rx_online) begin
      m_phase = 0; m_wait = 0; m_stb = 0; m_err = 0;
    end else if (m_phase == 0) begin
      m_phase = 1; m_wait = int'(delay_x_value);
    end else if (m_phase == 1) begin
      if (m_wait == 0) m_phase = 2;
      else m_wait--;
    end else if (m_phase == 2) begin
      m_stb = all_stb ? m_stb + 1 : 0;
      if (m_stb == int'(STB_CONSEC)) begin
        m_phase = 3; m_stb = 0; m_err = 0;
      end
    end else begin
      m_err = bad ? m_err + 1 : 0;
      if (m_err == int'(MAX_ERR)) begin
        m_phase = 2; m_err = 0; m_stb = 0;
      end
    end
  endtask

  task automatic cyc();
    model_clock();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_wr = 1'b1; rx_online = 1'b0; m_gen2_mode = 1'b1; delay_x_value = 16'd0;
    set_words(4'hF, GOOD);
    for (int i = 0; i < 3; i++) cyc();
    checks++;
    if ({rx_data, rx_data_vld, rx_online_delay, rx_aligned, mrk_err_cnt} !== 331'd0 || dbg !== 32'h0) begin
      errors++;
      $display("FAIL reset_state got vld=%b od=%b al=%b cnt=%0d dbg=%h data_nz=%b required all zero",
               rx_data_vld, rx_online_delay, rx_aligned, mrk_err_cnt, dbg, |rx_data);
    end
    rst_wr = 1'b0;
    cyc();
  endtask

  task automatic test_nominal_lock();
    m_gen2_mode = 1'b1; delay_x_value = 16'd5; rx_online = 1'b1;
    for (int j = 1; j <= 20; j++) begin
      set_words(4'hF, GOOD);
      cyc();
      checks++;
      if ({rx_online_delay, rx_aligned, rx_data_vld} !== {j >= 7, j >= 11, j >= 12}) begin
        errors++;
        $display("FAIL nominal_timing cycle %0d got od/al/vld=%b%b%b required %b%b%b", j,
                 rx_online_delay, rx_aligned, rx_data_vld, j >= 7, j >= 11, j >= 12);
      end
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL nominal_model cycle %0d got %h required %h", j, got_v, exp_v);
      end
    end
  endtask

  task automatic test_partial_strobe();
    logic [3:0] mask;
    rx_online = 1'b0;
    cyc();
    rx_online = 1'b1;
    delay_x_value = 16'($urandom_range(0, 3));
    for (int i = 0; i < 30; i++) begin
      mask = 4'hF;
      mask[2] = (i % 3 != 2);
      set_words(mask, GOOD);
      cyc();
      checks++;
      if (rx_aligned !== 1'b0 || dbg[9:6] > 4'd2 || got_v !== exp_v) begin
        errors++;
        $display("FAIL partial_strobe step %0d got al=%b stb_run=%0d vec %h required al=0 stb_run<=2 vec %h",
                 i, rx_aligned, dbg[9:6], got_v, exp_v);
      end
    end
    for (int k = 1; k <= 4; k++) begin
      set_words(4'hF, GOOD);
      cyc();
      checks++;
      if (rx_aligned !== (k == 4) || got_v !== exp_v) begin
        errors++;
        $display("FAIL strobe_restore step %0d got al=%b required %b", k, rx_aligned, k == 4);
      end
    end
  endtask

  task automatic test_marker_errors();
    for (int i = 0; i < 7; i++) begin
      set_words(4'hF, 8'b10_10_01_10);
      cyc();
      checks++;
      if (rx_aligned !== 1'b1 || rx_data_vld !== 1'b0 || got_v !== exp_v) begin
        errors++;
        $display("FAIL marker_short step %0d got al=%b vld=%b required al=1 vld=0", i, rx_aligned, rx_data_vld);
      end
    end
    checks++;
    if (mrk_err_cnt !== 8'd7) begin
      errors++;
      $display("FAIL marker_count7 got %0d required 7", mrk_err_cnt);
    end
    set_words(4'hF, GOOD);
    cyc();
    for (int i = 1; i <= 8; i++) begin
      set_words(4'hF, 8'b10_10_01_10);
      cyc();
      checks++;
      if (rx_aligned !== (i < 8) || rx_data_vld !== 1'b0 || got_v !== exp_v) begin
        errors++;
        $display("FAIL marker_unlock step %0d got al=%b vld=%b required al=%b vld=0",
                 i, rx_aligned, rx_data_vld, i < 8);
      end
    end
    checks++;
    if (mrk_err_cnt !== 8'd15 || dbg[11:10] !== 2'd2) begin
      errors++;
      $display("FAIL marker_count15 got cnt=%0d state=%0d required cnt=15 state=2", mrk_err_cnt, dbg[11:10]);
    end
  endtask

  task automatic test_gen1_mode();
    m_gen2_mode = 1'b0;
    for (int i = 0; i < 20; i++) begin
      set_words(4'hF, 8'h00);
      cyc();
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL gen1_model step %0d got %h required %h", i, got_v, exp_v);
      end
    end
    checks++;
    if (rx_aligned !== 1'b1 || rx_data_vld !== 1'b1 || mrk_err_cnt !== 8'd15) begin
      errors++;
      $display("FAIL gen1_clean got al=%b vld=%b cnt=%0d required 1 1 15", rx_aligned, rx_data_vld, mrk_err_cnt);
    end
    for (int i = 0; i < 2; i++) begin
      set_words(4'hF, 8'b01_00_00_00);
      cyc();
    end
    checks++;
    if (mrk_err_cnt !== 8'd17 || rx_data_vld !== 1'b0) begin
      errors++;
      $display("FAIL gen1_bit0_error got cnt=%0d vld=%b required 17 0", mrk_err_cnt, rx_data_vld);
    end
  endtask

  task automatic test_random();
    logic [3:0] mask;
    logic [7:0] mrk;
    for (int i = 0; i < 600; i++) begin
      if (i % 50 == 0) m_gen2_mode = 1'($urandom_range(0, 1));
      rst_wr        = ($urandom_range(0, 199) == 0);
      rx_online     = ($urandom_range(0, 49) != 0);
      delay_x_value = 16'($urandom_range(0, 6));
      mrk = GOOD;
      for (int c = 0; c < 4; c++) begin
        mask[c] = ($urandom_range(0, 19) != 0);
        if ($urandom_range(0, 9) == 0) mrk[2*c +: 2] = 2'($urandom_range(0, 3));
      end
      set_words(mask, mrk);
      cyc();
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL random_model step %0d got %h required %h", i, got_v, exp_v);
      end
    end
    rst_wr = 1'b0;
  endtask

  task automatic test_abort_saturate();
    int   saved;
    logic [7:0] prev;
    m_gen2_mode = 1'b1; delay_x_value = 16'd2; rx_online = 1'b1;
    for (int i = 0; i < 20 && m_phase != 3; i++) begin
      set_words(4'hF, GOOD);
      cyc();
    end
    checks++;
    if (rx_aligned !== 1'b1) begin
      errors++;
      $display("FAIL abort_prelock got al=%b required 1", rx_aligned);
    end
    saved = m_cnt;
    rx_online = 1'b0;
    set_words(4'hF, GOOD);
    cyc();
    checks++;
    if (rx_aligned !== 1'b0 || rx_online_delay !== 1'b0 || dbg[11:10] !== 2'd0 || mrk_err_cnt !== 8'(saved)) begin
      errors++;
      $display("FAIL abort_idle got al=%b od=%b state=%0d cnt=%0d required 0 0 0 %0d",
               rx_aligned, rx_online_delay, dbg[11:10], mrk_err_cnt, saved);
    end
    rx_online = 1'b1; delay_x_value = 16'd0;
    prev = mrk_err_cnt;
    for (int i = 0; i < 600; i++) begin
      set_words(4'hF, 8'b01_01_01_01);
      cyc();
      checks++;
      if (got_v !== exp_v || mrk_err_cnt < prev) begin
        errors++;
        $display("FAIL saturate_model step %0d got %h required %h", i, got_v, exp_v);
      end
      prev = mrk_err_cnt;
    end
    checks++;
    if (mrk_err_cnt !== 8'hFF) begin
      errors++;
      $display("FAIL saturate_hold got %h required ff", mrk_err_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_nominal_lock();
    test_partial_strobe();
    test_marker_errors();
    test_gen1_mode();
    test_random();
    test_abort_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
